// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter stage: redirect source codes,
// default vectors and a small source-classification helper.
package pc_pkg;

    // Encoding doubles as priority: a larger code wins.
    typedef enum logic [1:0] {
        SRC_SEQ    = 2'd0,
        SRC_JUMP   = 2'd1,
        SRC_BRANCH = 2'd2,
        SRC_EXC    = 2'd3
    } pc_src_e;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_EXC_VECTOR   = 32'h8000_0180;
    localparam int unsigned DEF_INC          = 32'd4;

    function automatic logic src_checks_align(input pc_src_e src);
        return (src == SRC_BRANCH) || (src == SRC_JUMP);
    endfunction

endpackage

// File: rtl/pc_unit_if.sv
// Request/result bundle between the pipeline control and the PC stage.
// The master drives redirect requests; the slave (pc_unit) returns the fetch PC.
interface pc_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             PCWrite;
    logic             BranchTaken;
    logic [WIDTH-1:0] BranchTarget;
    logic             Jump;
    logic [WIDTH-1:0] JumpTarget;
    logic             Exception;
    logic [WIDTH-1:0] ExcPC;
    logic [WIDTH-1:0] PCResult;
    logic [WIDTH-1:0] PCPlusInc;
    logic             FetchValid;
    logic [WIDTH-1:0] EPC;
    logic             AlignErr;

    modport master (
        output PCWrite, BranchTaken, BranchTarget, Jump, JumpTarget, Exception, ExcPC,
        input  PCResult, PCPlusInc, FetchValid, EPC, AlignErr
    );

    modport slave (
        input  PCWrite, BranchTaken, BranchTarget, Jump, JumpTarget, Exception, ExcPC,
        output PCResult, PCPlusInc, FetchValid, EPC, AlignErr
    );

endinterface

// File: rtl/pc_redirect_buf.sv
// Single-entry pending-redirect holder used while the PC is stalled.
// A new request replaces the stored one only if its priority is not lower.
module pc_redirect_buf
    import pc_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             clear_i,
    input  logic             wr_en_i,
    input  pc_src_e          wr_src_i,
    input  logic [WIDTH-1:0] wr_target_i,
    output logic             valid_o,
    output pc_src_e          src_o,
    output logic [WIDTH-1:0] target_o
);

    logic             valid_q,  valid_d;
    pc_src_e          src_q,    src_d;
    logic [WIDTH-1:0] target_q, target_d;

    // Next-state: clear wins, else accept an equal-or-higher priority write.
    always_comb begin
        valid_d  = valid_q;
        src_d    = src_q;
        target_d = target_q;
        if (clear_i) begin
            valid_d  = 1'b0;
            src_d    = SRC_SEQ;
            target_d = '0;
        end else if (wr_en_i && (!valid_q || (wr_src_i >= src_q))) begin
            valid_d  = 1'b1;
            src_d    = wr_src_i;
            target_d = wr_target_i;
        end else begin
            valid_d  = valid_q;
        end
    end

    // Pending-entry state register with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q  <= 1'b0;
            src_q    <= SRC_SEQ;
            target_q <= '0;
        end else begin
            valid_q  <= valid_d;
            src_q    <= src_d;
            target_q <= target_d;
        end
    end

    assign valid_o  = valid_q;
    assign src_o    = src_q;
    assign target_o = target_q;

endmodule

// File: rtl/pc_unit.sv
// Program-counter stage: next-PC selection over exception/branch/jump/pending/
// sequential sources, stall buffering, EPC capture and target alignment.
// Define PC_TRACE_EN to print every PC update in simulation.
module pc_unit
    import pc_pkg::*;
#(
    parameter int unsigned      WIDTH        = 32,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEF_RESET_VECTOR),
    parameter logic [WIDTH-1:0] EXC_VECTOR   = WIDTH'(DEF_EXC_VECTOR),
    parameter int unsigned      INC          = DEF_INC
) (
    input logic      Clk,
    input logic      Reset,
    pc_unit_if.slave bus
);

    // Bits below the increment granularity must be zero in any fetch target.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'(INC - 32'd1);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [WIDTH-1:0] epc_q, epc_d;
    logic             fetch_valid_q, fetch_valid_d;
    logic             align_err_q, align_err_d;

    logic             live_valid_s;
    pc_src_e          live_src_s;
    logic [WIDTH-1:0] live_tgt_s;

    logic             pend_valid_s;
    pc_src_e          pend_src_s;
    logic [WIDTH-1:0] pend_tgt_s;

    pc_src_e          sel_src_s;
    logic [WIDTH-1:0] sel_tgt_s;
    logic [WIDTH-1:0] pc_plus_inc_s;
    logic             misalign_s;

    assign pc_plus_inc_s = pc_q + WIDTH'(INC);

    // Highest-priority request presented this cycle.
    always_comb begin
        live_valid_s = 1'b0;
        live_src_s   = SRC_SEQ;
        live_tgt_s   = '0;
        if (bus.Exception) begin
            live_valid_s = 1'b1;
            live_src_s   = SRC_EXC;
            live_tgt_s   = EXC_VECTOR;
        end else if (bus.BranchTaken) begin
            live_valid_s = 1'b1;
            live_src_s   = SRC_BRANCH;
            live_tgt_s   = bus.BranchTarget;
        end else if (bus.Jump) begin
            live_valid_s = 1'b1;
            live_src_s   = SRC_JUMP;
            live_tgt_s   = bus.JumpTarget;
        end else begin
            live_valid_s = 1'b0;
        end
    end

    pc_redirect_buf #(
        .WIDTH (WIDTH)
    ) u_redirect_buf (
        .clk_i       (Clk),
        .rst_i       (Reset),
        .clear_i     (bus.PCWrite),
        .wr_en_i     (!bus.PCWrite && live_valid_s),
        .wr_src_i    (live_src_s),
        .wr_target_i (live_tgt_s),
        .valid_o     (pend_valid_s),
        .src_o       (pend_src_s),
        .target_o    (pend_tgt_s)
    );

    // Next-PC selection, alignment forcing and the remaining next-state terms.
    always_comb begin
        sel_src_s = SRC_SEQ;
        sel_tgt_s = pc_plus_inc_s;
        if (live_valid_s) begin
            sel_src_s = live_src_s;
            sel_tgt_s = live_tgt_s;
        end else if (pend_valid_s) begin
            sel_src_s = pend_src_s;
            sel_tgt_s = pend_tgt_s;
        end else begin
            sel_src_s = SRC_SEQ;
        end

        misalign_s = src_checks_align(sel_src_s) && ((sel_tgt_s & ALIGN_MASK) != '0);

        if (bus.PCWrite) begin
            pc_d        = src_checks_align(sel_src_s) ? (sel_tgt_s & ~ALIGN_MASK) : sel_tgt_s;
            align_err_d = misalign_s;
        end else begin
            pc_d        = pc_q;
            align_err_d = 1'b0;
        end

        fetch_valid_d = fetch_valid_q | bus.PCWrite;

        if (bus.Exception) begin
            epc_d = bus.ExcPC;
        end else begin
            epc_d = epc_q;
        end
    end

    // Architectural PC-stage registers; reset overrides every request.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pc_q          <= RESET_VECTOR;
            epc_q         <= '0;
            fetch_valid_q <= 1'b0;
            align_err_q   <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            epc_q         <= epc_d;
            fetch_valid_q <= fetch_valid_d;
            align_err_q   <= align_err_d;
        end
    end

    assign bus.PCResult   = pc_q;
    assign bus.PCPlusInc  = pc_plus_inc_s;
    assign bus.FetchValid = fetch_valid_q;
    assign bus.EPC        = epc_q;
    assign bus.AlignErr   = align_err_q;

`ifdef PC_TRACE_EN
    // Simulation trace of each PC update.
    always_ff @(posedge Clk) begin
        if (!Reset && bus.PCWrite) begin
            $display("PC=%h%s", pc_d, (sel_src_s != SRC_SEQ) ? " REDIR" : "");
        end
    end
`else
`endif

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed vectors push hand-computed results,
// a negedge monitor pops and compares them against the DUT outputs.
module tb_pc_unit;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    typedef struct {
        string       name;
        int          cyc;
        logic [31:0] pc;
        logic        fv;
        logic        ae;
        logic [31:0] epc;
    } exp_t;

    exp_t sb[$];

    pc_unit_if #(.WIDTH(32)) bus ();

    pc_unit #(
        .WIDTH        (32),
        .RESET_VECTOR (32'h0000_0000),
        .EXC_VECTOR   (32'h8000_0180),
        .INC          (4)
    ) dut (
        .Clk   (clk),
        .Reset (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input string field, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s.%s: got %h expected %h", name, field, act, exp);
        end
    endtask

    // Monitor: compare the entry scheduled for this cycle.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            exp_t e;
            logic [31:0] inc_exp;
            e = sb.pop_front();
            inc_exp = e.pc + 32'd4;
            chk(e.name, "PCResult",   bus.PCResult,          e.pc);
            chk(e.name, "PCPlusInc",  bus.PCPlusInc,         inc_exp);
            chk(e.name, "FetchValid", {31'd0, bus.FetchValid}, {31'd0, e.fv});
            chk(e.name, "AlignErr",   {31'd0, bus.AlignErr},   {31'd0, e.ae});
            chk(e.name, "EPC",        bus.EPC,               e.epc);
        end
    end

    // Drive one cycle of inputs and schedule the result expected after the edge.
    task automatic step(input string name, input logic r, input logic pw,
                        input logic exc, input logic [31:0] ep,
                        input logic br, input logic [31:0] bt,
                        input logic jp, input logic [31:0] jt,
                        input logic [31:0] e_pc, input logic e_fv,
                        input logic e_ae, input logic [31:0] e_epc);
        exp_t e;
        rst              = r;
        bus.PCWrite      = pw;
        bus.Exception    = exc;
        bus.ExcPC        = ep;
        bus.BranchTaken  = br;
        bus.BranchTarget = bt;
        bus.Jump         = jp;
        bus.JumpTarget   = jt;
        e.name = name;
        e.cyc  = cyc + 1;
        e.pc   = e_pc;
        e.fv   = e_fv;
        e.ae   = e_ae;
        e.epc  = e_epc;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b1;
        bus.PCWrite      = 1'b0;
        bus.Exception    = 1'b0;
        bus.ExcPC        = 32'd0;
        bus.BranchTaken  = 1'b0;
        bus.BranchTarget = 32'd0;
        bus.Jump         = 1'b0;
        bus.JumpTarget   = 32'd0;
        @(posedge clk);
        #1;
        //    name          rst   pw    exc   excpc         br    btgt          jp    jtgt          pc            fv    ae    epc
        step("rst",        1'b1, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0);
        step("rst_ovr",    1'b1, 1'b1, 1'b1, 32'h99,       1'b1, 32'h100,      1'b1, 32'h200,      32'h0,        1'b0, 1'b0, 32'h0);
        step("seq1",       1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h4,        1'b1, 1'b0, 32'h0);
        step("seq2",       1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h8,        1'b1, 1'b0, 32'h0);
        step("seq3",       1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'hC,        1'b1, 1'b0, 32'h0);
        step("br_stall1",  1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h100,      1'b0, 32'h0,        32'hC,        1'b1, 1'b0, 32'h0);
        step("br_stall2",  1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h100,      1'b0, 32'h0,        32'hC,        1'b1, 1'b0, 32'h0);
        step("br_release", 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h100,      1'b1, 1'b0, 32'h0);
        step("br_seq",     1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h104,      1'b1, 1'b0, 32'h0);
        step("jp_stall",   1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h200,      32'h104,      1'b1, 1'b0, 32'h0);
        step("br_replace", 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h300,      1'b0, 32'h0,        32'h104,      1'b1, 1'b0, 32'h0);
        step("repl_rel",   1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h300,      1'b1, 1'b0, 32'h0);
        step("br_stall3",  1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h400,      1'b0, 32'h0,        32'h300,      1'b1, 1'b0, 32'h0);
        step("jp_dropped", 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h600,      32'h300,      1'b1, 1'b0, 32'h0);
        step("drop_rel",   1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h400,      1'b1, 1'b0, 32'h0);
        step("drop_seq",   1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h404,      1'b1, 1'b0, 32'h0);
        step("exc_all",    1'b0, 1'b1, 1'b1, 32'h44,       1'b1, 32'h500,      1'b1, 32'h700,      32'h80000180, 1'b1, 1'b0, 32'h44);
        step("exc_seq",    1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h80000184, 1'b1, 1'b0, 32'h44);
        step("exc_stall",  1'b0, 1'b0, 1'b1, 32'h88,       1'b0, 32'h0,        1'b0, 32'h0,        32'h80000184, 1'b1, 1'b0, 32'h88);
        step("br_vs_exc",  1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h900,      1'b0, 32'h0,        32'h80000184, 1'b1, 1'b0, 32'h88);
        step("exc_rel",    1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h80000180, 1'b1, 1'b0, 32'h88);
        step("jp_misal",   1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'h203,      32'h200,      1'b1, 1'b1, 32'h88);
        step("ae_pulse",   1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h204,      1'b1, 1'b0, 32'h88);
        step("br_mis_stl", 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h302,      1'b0, 32'h0,        32'h204,      1'b1, 1'b0, 32'h88);
        step("br_mis_rel", 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h300,      1'b1, 1'b1, 32'h88);
        step("ae_clear",   1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h304,      1'b1, 1'b0, 32'h88);
        step("pend_br",    1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h800,      1'b0, 32'h0,        32'h304,      1'b1, 1'b0, 32'h88);
        step("rst_stall",  1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0, 1'b0, 32'h0);
        step("rst_no_pnd", 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h4,        1'b1, 1'b0, 32'h0);
        step("jp_top",     1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1, 32'hFFFFFFFC, 32'hFFFFFFFC, 1'b1, 1'b0, 32'h0);
        step("wrap",       1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h0,        1'b1, 1'b0, 32'h0);
        step("br_over_jp", 1'b0, 1'b1, 1'b0, 32'h0,        1'b1, 32'h1000,     1'b1, 32'h2000,     32'h1000,     1'b1, 1'b0, 32'h0);
        step("idle_stall", 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0, 32'h0,        32'h1000,     1'b1, 1'b0, 32'h0);

        for (int i = 0; i < 5 && sb.size() > 0; i++) begin
            @(posedge clk);
        end
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d entries left, expected 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Parametrised program-counter stage for the pipelined core.
- Replaces the plain PC register with next-PC selection across four sources: sequential, branch, jump and exception vector.
- Holds redirects that arrive during a stall so none is lost; captures the exception PC; flags misaligned targets.
- Sits at the head of IF; feeds instruction memory and the IF/ID register.

Parameters:
- WIDTH, 32, PC width in bits (>= 8).
- RESET_VECTOR, 32'h00000000, PC value after reset.
- EXC_VECTOR, 32'h80000180, exception handler address.
- INC, 4, sequential increment; power of two.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- PCWrite  in  1  1 = PC may advance; 0 = stall (hold PC).
- BranchTaken  in  1  branch redirect request.
- BranchTarget  in  WIDTH  branch target.
- Jump  in  1  jump redirect request.
- JumpTarget  in  WIDTH  jump target.
- Exception  in  1  exception redirect request.
- ExcPC  in  WIDTH  PC of the faulting instruction.
- PCResult  out  WIDTH  current fetch PC (registered).
- PCPlusInc  out  WIDTH  PCResult + INC (combinational, modulo 2^WIDTH).
- FetchValid  out  1  PCResult holds a fetchable address.
- EPC  out  WIDTH  last captured exception PC (registered).
- AlignErr  out  1  one-cycle pulse: a misaligned target was accepted.

Behaviour:
- Reset (sync, checked first each edge): PCResult=RESET_VECTOR, EPC=0, FetchValid=0, AlignErr=0, pending buffer empty.
  - Reset overrides every request in the same cycle.
  - Reset mid-stall discards any pending redirect.
- Request priority, fixed: Exception > BranchTaken > Jump > pending > sequential.
- Source selection:
  - Exception: target EXC_VECTOR; EPC<=ExcPC on the same edge, regardless of PCWrite.
  - Branch: target BranchTarget. Jump: target JumpTarget.
- PCWrite=1: PCResult <= highest-priority live source, else the pending target, else PCResult+INC.
  - Pending buffer is cleared on the same edge.
  - Latency: a redirect seen at edge N appears on PCResult after edge N.
- PCWrite=0 (stall): PCResult holds.
  - Any live request is written into the pending buffer (valid bit + target + priority code).
  - A new request replaces the pending one if its priority is >= the stored one; otherwise it is dropped.
- FetchValid: 0 after reset; set on the first edge with PCWrite=1; stays 1 until the next Reset.
- Alignment, for non-sequential targets when the request is accepted:
  - The target's low log2(INC) bits are forced to 0 before loading.
  - AlignErr pulses high for the cycle after the edge where any forced bit was 1.
  - EXC_VECTOR and RESET_VECTOR are assumed aligned and are never checked.
- Wrap-around: PCResult+INC wraps modulo 2^WIDTH; no error flagged.
- Simultaneous Exception + Branch + Jump: Exception wins; the others are dropped and are not buffered.

Optional Feature:
- Macro: PC_TRACE_EN.
- Defined: on every edge where PCResult updates, simulation prints "PC=%h" with the new value, plus " REDIR" when the source was not sequential; no synthesis impact.
- Undefined: no display statements are compiled.

Decomposition:
- Shared package pc_pkg:
  - 2-bit source code enum: SRC_SEQ, SRC_JUMP, SRC_BRANCH, SRC_EXC, encoded as 0/1/2/3 to match priority order.
  - Default vector constants.
- One sub-module: pc_redirect_buf, the pending valid/target/priority register with its replace rule.

Test Plan:
- Reset then 3 cycles with PCWrite=1 -> PCResult 0x0, 0x4, 0x8, 0xC; FetchValid 0 then 1.
- BranchTaken=1, BranchTarget=0x100 while PCWrite=0 for 2 cycles, then PCWrite=1 -> PC holds, then 0x100, then 0x104.
- During a stall: Jump to 0x200 at cycle 1, Branch to 0x300 at cycle 2; release -> PC=0x300 (branch replaces jump).
- Exception with ExcPC=0x44 alongside Branch to 0x500 -> PCResult=0x80000180, EPC=0x44.
- Jump to 0x203 -> PCResult=0x200, AlignErr high for exactly one cycle.
- Reset asserted during a stall with a pending branch -> PCResult=RESET_VECTOR and buffer empty; next PCWrite=1 -> RESET_VECTOR+4.
